// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the board-to-pixel clock ratio.
package vga_timing_pkg;
   localparam int VGA_CW       = 12;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam bit VGA_HSYNC_POL = 1'b0;
   localparam bit VGA_VSYNC_POL = 1'b0;

   localparam int VGA_SYS_CLK_HZ     = 100_000_000;
   localparam int VGA_PIX_CLK_HZ     = 25_000_000;
   localparam int VGA_CLKS_PER_PIXEL = VGA_SYS_CLK_HZ / VGA_PIX_CLK_HZ;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wraps 0..TOTAL-1 on step; wrap/sync/active decodes are
// combinational from the registered count, so they describe the current position.
module timing_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int CW     = VGA_CW,
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          in_sync,
   output logic          in_active
);
   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC - 1);
   localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);

   if (CW < 1 || CW > 30 || TOTAL > (1 << CW)) begin : g_cw_chk
      $error("timing_axis_counter: CW too narrow for axis total");
   end

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (step) count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count     = count_q;
   assign wrap      = step & (count_q == LAST);
   assign in_sync   = (count_q >= SYNC_LO) & (count_q <= SYNC_HI);
   assign in_active = count_q < ACT_END;
endmodule

// File: rtl/vga_timing_gen.sv
// Full H/V raster timing: prescaler, position counters, syncs, video_on and strobes.
// Sync/video/frame outputs lag the counters by one clk; en=0 freezes everything.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLKS_PER_PIXEL = VGA_CLKS_PER_PIXEL,
   parameter int CW             = VGA_CW,
   parameter int H_ACTIVE       = VGA_H_ACTIVE,
   parameter int H_FP           = VGA_H_FP,
   parameter int H_SYNC         = VGA_H_SYNC,
   parameter int H_BP           = VGA_H_BP,
   parameter int V_ACTIVE       = VGA_V_ACTIVE,
   parameter int V_FP           = VGA_V_FP,
   parameter int V_SYNC         = VGA_V_SYNC,
   parameter int V_BP           = VGA_V_BP,
   parameter bit HSYNC_POL      = VGA_HSYNC_POL,
   parameter bit VSYNC_POL      = VGA_VSYNC_POL
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [CW-1:0] h_count,
   output logic [CW-1:0] v_count,
   output logic          pixel_tick,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          line_end,
   output logic          frame_start
);
   localparam int PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_PIXEL - 1);

   if (CLKS_PER_PIXEL < 1) begin : g_cpp_chk
      $error("vga_timing_gen: CLKS_PER_PIXEL must be >= 1");
   end

   logic [PW-1:0] pre_q, pre_d;
   logic hsync_q, hsync_d, vsync_q, vsync_d;
   logic video_on_q, video_on_d, frame_start_q, frame_start_d;
   logic pending_q, pending_d;
   logic h_in_sync, h_in_active, v_in_sync, v_in_active, v_wrap;

   assign pixel_tick = en & (pre_q == PRE_LAST);

   timing_axis_counter #(
      .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
   ) u_h_axis (
      .clk(clk), .reset(reset), .step(pixel_tick), .count(h_count),
      .wrap(line_end), .in_sync(h_in_sync), .in_active(h_in_active)
   );

   timing_axis_counter #(
      .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
   ) u_v_axis (
      .clk(clk), .reset(reset), .step(line_end), .count(v_count),
      .wrap(v_wrap), .in_sync(v_in_sync), .in_active(v_in_active)
   );

   // pending marks "sitting at (0,0) and not yet announced"; armed by reset and frame wrap.
   always_comb begin
      pre_d         = pre_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      frame_start_d = 1'b0;
      pending_d     = pending_q;
      if (en) begin
         pre_d         = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
         hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
         vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
         video_on_d    = h_in_active & v_in_active;
         frame_start_d = pending_q & (pre_q == '0);
         if (frame_start_d) pending_d = 1'b0;
      end
      if (v_wrap) pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q         <= '0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         pending_q     <= 1'b1;
      end else begin
         pre_q         <= pre_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         pending_q     <= pending_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
endmodule
